// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares the single synchronous port of one sprite/map/collision
//               RAM between two clients.
//                 D (display) - read-only, default priority (feeds VGA pipeline)
//                 L (logic)   - reads and writes (movement / collision logic)
//               Issues at most one RAM operation per cycle. In-flight reads are
//               tagged with their owner and the returned data is steered back
//               to that client. A starvation guard bounds how long L can be
//               held off by a continuously requesting D.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW           address width
//   DW           data width
//   RAM_LAT      RAM read latency in cycles (addr at t -> ram_rdata at t+RAM_LAT), >= 1
//   STARVE_LIMIT consecutive denied L cycles before L is forced through;
//                0 gives D strict priority
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   d_req      in   1   D read request, held until d_gnt
//   d_addr     in   AW  D read address
//   d_gnt      out  1   D operation issued this cycle (combinational)
//   d_rvalid   out  1   one-cycle pulse: d_rdata updated
//   d_rdata    out  DW  last D read data (held)
//   l_req      in   1   L request, held with l_we/l_addr/l_wdata until l_gnt
//   l_we       in   1   1 = write, 0 = read
//   l_addr     in   AW  L address
//   l_wdata    in   DW  L write data
//   l_gnt      out  1   L operation issued this cycle (combinational)
//   l_rvalid   out  1   one-cycle pulse: l_rdata updated (reads only)
//   l_rdata    out  DW  last L read data (held)
//   ram_addr   out  AW  RAM read/write address
//   ram_we     out  1   RAM write enable
//   ram_wdata  out  DW  RAM write data
//   ram_rdata  in   DW  RAM read data
// ============================================================================
module ram_port_arbiter #(
    parameter int unsigned AW           = 19,
    parameter int unsigned DW           = 8,
    parameter int unsigned RAM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // With STARVE_LIMIT = 0 the counter is never consulted, but a one-bit
    // register is kept so the logic stays uniform.
    localparam int unsigned   c_starve_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_starve_w-1:0] c_starve_limit = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_starve_max   = '1;

    // Tag owner encoding: 0 = D, 1 = L
    localparam logic c_own_d = 1'b0;
    localparam logic c_own_l = 1'b1;

    logic [c_starve_w-1:0] r_starve_cnt;
    logic                  w_force;
    logic                  w_l_gnt;
    logic                  w_d_gnt;

    logic [RAM_LAT-1:0]    r_tag_vld;
    logic [RAM_LAT-1:0]    r_tag_own;
    logic                  w_tag_in_vld;
    logic                  w_tag_in_own;
    logic                  w_ret_vld;
    logic                  w_ret_own;

    logic                  r_d_rvalid;
    logic                  r_l_rvalid;
    logic [DW-1:0]         r_d_rdata;
    logic [DW-1:0]         r_l_rdata;

    // ------------------------------------------------------------------------
    // Grant. L wins whenever D is idle, or when the starvation guard fires.
    // Both grants are suppressed while reset is asserted so no RAM write can
    // slip out during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_force = 1'b0;
        if (STARVE_LIMIT != 0) begin
            w_force = (r_starve_cnt >= c_starve_limit);
        end
        w_l_gnt = rst_n & l_req & (~d_req | w_force);
        w_d_gnt = rst_n & d_req & ~w_l_gnt;
    end

    assign d_gnt = w_d_gnt;
    assign l_gnt = w_l_gnt;

    // ------------------------------------------------------------------------
    // RAM drive. The address defaults to D so an idle cycle reads D's address
    // harmlessly; the write enable is only ever raised by a granted L write.
    // ------------------------------------------------------------------------
    assign ram_addr  = w_l_gnt ? l_addr : d_addr;
    assign ram_we    = w_l_gnt & l_we;
    assign ram_wdata = l_wdata;

    // ------------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles in which L asks and is
    // refused. Once it reaches STARVE_LIMIT, L is forced through on the next
    // cycle and the grant clears the count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_l_gnt || !l_req) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipeline: one {valid, owner} entry per RAM latency stage, so that
    // the entry reaches the last stage in the same cycle the RAM presents the
    // matching read data. Writes load an invalid entry.
    // ------------------------------------------------------------------------
    assign w_tag_in_vld = w_d_gnt | (w_l_gnt & ~l_we);
    assign w_tag_in_own = w_l_gnt ? c_own_l : c_own_d;

    generate
        if (RAM_LAT == 1) begin : g_tag_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_vld <= '0;
                    r_tag_own <= '0;
                end else begin
                    r_tag_vld <= w_tag_in_vld;
                    r_tag_own <= w_tag_in_own;
                end
            end
        end else begin : g_tag_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_vld <= '0;
                    r_tag_own <= '0;
                end else begin
                    r_tag_vld <= {r_tag_vld[RAM_LAT-2:0], w_tag_in_vld};
                    r_tag_own <= {r_tag_own[RAM_LAT-2:0], w_tag_in_own};
                end
            end
        end
    endgenerate

    assign w_ret_vld = r_tag_vld[RAM_LAT-1];
    assign w_ret_own = r_tag_own[RAM_LAT-1];

    // ------------------------------------------------------------------------
    // Return path: capture the RAM data into the owner's holding register and
    // pulse its rvalid. The other client's data register is left untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_l_rdata  <= '0;
        end else begin
            r_d_rvalid <= w_ret_vld & (w_ret_own == c_own_d);
            r_l_rvalid <= w_ret_vld & (w_ret_own == c_own_l);
            if (w_ret_vld && (w_ret_own == c_own_d)) begin
                r_d_rdata <= ram_rdata;
            end
            if (w_ret_vld && (w_ret_own == c_own_l)) begin
                r_l_rdata <= ram_rdata;
            end
        end
    end

    assign d_rvalid = r_d_rvalid;
    assign l_rvalid = r_l_rvalid;
    assign d_rdata  = r_d_rdata;
    assign l_rdata  = r_l_rdata;

endmodule
`default_nettype wire
